// File: rtl/wavegen_pkg.sv
// Shared constants for the DDS waveform generator: waveform modes and
// the configuration handshake state encoding.
package wavegen_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_SQUARE   = 2'd0;
   localparam mode_t MODE_SAW      = 2'd1;
   localparam mode_t MODE_TRI      = 2'd2;
   localparam mode_t MODE_SQUARE2X = 2'd3;

   typedef enum logic {
      CFG_READY   = 1'b0,
      CFG_PENDING = 1'b1
   } cfg_state_t;

endpackage

// File: rtl/wave_shaper.sv
// Combinational phase-to-sample mapping for the four waveform modes.
module wave_shaper
   import wavegen_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] i_phase,
   input  mode_t             i_mode,
   input  logic [DATA_W-1:0] i_duty,
   output logic [DATA_W-1:0] o_sample
);

   logic [DATA_W-1:0] w_dbl;

   assign w_dbl = {i_phase[DATA_W-2:0], 1'b0};

   always_comb begin
      o_sample = '0;
      case (i_mode)
         MODE_SQUARE: o_sample = (i_phase < i_duty) ? '0 : '1;
         MODE_SAW:    o_sample = i_phase;
         // Falling half mirrors the rising half, so the peak sits at MAX.
         MODE_TRI:    o_sample = i_phase[DATA_W-1] ? ~w_dbl : w_dbl;
         default:     o_sample = i_phase[DATA_W-2] ? '1 : '0;
      endcase
   end

endmodule

// File: rtl/wavegen_dds.sv
// Phase-accumulator waveform generator; new configs are shadowed and only
// take effect at a period boundary (carry-out) or while the generator is halted.
module wavegen_dds
   import wavegen_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ACC_W   = 16,
   parameter int RST_INC = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [1:0]        cfg_mode,
   input  logic [ACC_W-1:0]  cfg_inc,
   input  logic [DATA_W-1:0] cfg_duty,
   output logic [DATA_W-1:0] op,
   output logic              wrap
);

   cfg_state_t        r_state;
   cfg_state_t        w_state_nxt;
   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  r_inc;
   logic [ACC_W-1:0]  r_sh_inc;
   mode_t             r_mode;
   mode_t             r_sh_mode;
   logic [DATA_W-1:0] r_duty;
   logic [DATA_W-1:0] r_sh_duty;
   logic [DATA_W-1:0] r_op;
   logic              r_wrap;
   logic [ACC_W-1:0]  w_sum;
   logic              w_carry;
   logic              w_capture;
   logic              w_apply;
   logic [DATA_W-1:0] w_sample;

   assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_inc};

   wave_shaper #(.DATA_W(DATA_W)) u_shaper (
      .i_phase  (r_acc[ACC_W-1 -: DATA_W]),
      .i_mode   (r_mode),
      .i_duty   (r_duty),
      .o_sample (w_sample)
   );

   always_ff @(posedge clk) begin
      if (!rst) r_state <= CFG_READY;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         CFG_READY:   if (cfg_valid) w_state_nxt = CFG_PENDING;
         CFG_PENDING: if (!en || w_carry) w_state_nxt = CFG_READY;
         default:     w_state_nxt = CFG_READY;
      endcase
   end

   // A halted generator has no boundary to wait for, so apply immediately.
   always_comb begin
      cfg_ready = (r_state == CFG_READY);
      w_capture = (r_state == CFG_READY) && cfg_valid;
      w_apply   = (r_state == CFG_PENDING) && (!en || w_carry);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc     <= '0;
         r_inc     <= ACC_W'(RST_INC);
         r_mode    <= MODE_SQUARE;
         r_duty    <= {1'b1, {(DATA_W-1){1'b0}}};
         r_sh_inc  <= '0;
         r_sh_mode <= MODE_SQUARE;
         r_sh_duty <= '0;
         r_op      <= '0;
         r_wrap    <= 1'b0;
      end else begin
         if (en) r_acc <= w_sum;
         r_wrap <= en && w_carry;
         r_op   <= w_sample;
         if (w_capture) begin
            r_sh_inc  <= cfg_inc;
            r_sh_mode <= cfg_mode;
            r_sh_duty <= cfg_duty;
         end
         if (w_apply) begin
            r_inc  <= r_sh_inc;
            r_mode <= r_sh_mode;
            r_duty <= r_sh_duty;
         end
      end
   end

   assign op   = r_op;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_wavegen_dds.sv
// Directed scenario bench for wavegen_dds at DATA_W=8, ACC_W=16, RST_INC=256.
module tb_wavegen_dds;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_mode;
   logic [15:0] cfg_inc;
   logic [7:0]  cfg_duty;
   logic [7:0]  op;
   logic        wrap;

   int total = 0;
   int bad   = 0;

   wavegen_dds #(.DATA_W(8), .ACC_W(16), .RST_INC(256)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_mode  (cfg_mode),
      .cfg_inc   (cfg_inc),
      .cfg_duty  (cfg_duty),
      .op        (op),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic offer(input logic [1:0] m, input logic [15:0] inc, input logic [7:0] d);
      cfg_valid = 1'b1;
      cfg_mode  = m;
      cfg_inc   = inc;
      cfg_duty  = d;
   endtask

   task automatic test_reset;
      rst = 1'b0; en = 1'b0; cfg_valid = 1'b0;
      cfg_mode = 2'd0; cfg_inc = 16'd0; cfg_duty = 8'd0;
      repeat (3) tick();
      total++; if (op !== 8'd0) begin bad++; $display("FAIL reset_op got=%0d want=0", op); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%0b want=0", wrap); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", cfg_ready); end
   endtask

   // Default square, inc=256: p advances one per edge, op lags p by one edge.
   task automatic test_square_default;
      logic [7:0] exp_op;
      logic       exp_wrap;
      rst = 1'b1; en = 1'b1;
      for (int k = 1; k <= 512; k++) begin
         tick();
         exp_op   = (((k - 1) % 256) < 128) ? 8'd0 : 8'd255;
         exp_wrap = (k % 256 == 0);
         total++; if (op !== exp_op) begin bad++; $display("FAIL sq_default_op k=%0d got=%0d want=%0d", k, op, exp_op); end
         total++; if (wrap !== exp_wrap) begin bad++; $display("FAIL sq_default_wrap k=%0d got=%0b want=%0b", k, wrap, exp_wrap); end
         total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL sq_default_ready k=%0d got=%0b want=1", k, cfg_ready); end
      end
   endtask

   task automatic test_saw_cfg;
      offer(2'd1, 16'd256, 8'd128);
      tick();
      cfg_valid = 1'b0;
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL saw_accept_ready got=%0b want=0", cfg_ready); end
      for (int j = 2; j <= 256; j++) begin
         tick();
         total++; if (cfg_ready !== (j == 256)) begin bad++; $display("FAIL saw_pending_ready j=%0d got=%0b want=%0b", j, cfg_ready, (j == 256)); end
         total++; if (wrap !== (j == 256)) begin bad++; $display("FAIL saw_pending_wrap j=%0d got=%0b want=%0b", j, wrap, (j == 256)); end
      end
      for (int i = 0; i < 256; i++) begin
         tick();
         total++; if (op !== 8'(i)) begin bad++; $display("FAIL saw_op i=%0d got=%0d want=%0d", i, op, i); end
         total++; if (wrap !== (i == 255)) begin bad++; $display("FAIL saw_wrap i=%0d got=%0b want=%0b", i, wrap, (i == 255)); end
      end
   endtask

   // Triangle at inc=512: 128-cycle period, 0,4,..,252 then 255,251,..,3.
   task automatic test_tri;
      int idx;
      logic [7:0] exp_op;
      offer(2'd2, 16'd512, 8'd128);
      tick();
      cfg_valid = 1'b0;
      for (int j = 2; j <= 256; j++) begin
         tick();
         total++; if (cfg_ready !== (j == 256)) begin bad++; $display("FAIL tri_pending_ready j=%0d got=%0b want=%0b", j, cfg_ready, (j == 256)); end
      end
      for (int i = 0; i < 256; i++) begin
         tick();
         idx    = i % 128;
         exp_op = (idx < 64) ? 8'(4 * idx) : 8'(255 - 4 * (idx - 64));
         total++; if (op !== exp_op) begin bad++; $display("FAIL tri_op i=%0d got=%0d want=%0d", i, op, exp_op); end
         total++; if (wrap !== (idx == 127)) begin bad++; $display("FAIL tri_wrap i=%0d got=%0b want=%0b", i, wrap, (idx == 127)); end
      end
   endtask

   task automatic test_square2x;
      int accepts = 0;
      logic [7:0] exp_op;
      offer(2'd0, 16'd256, 8'd128);
      tick();
      cfg_valid = 1'b0;
      for (int j = 2; j <= 128; j++) tick();
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL sq_restore_ready got=%0b want=1", cfg_ready); end
      repeat (64) tick();
      offer(2'd3, 16'd256, 8'd128);
      for (int n = 1; n <= 192; n++) begin
         cfg_valid = (n <= 10);
         if (cfg_valid && cfg_ready) accepts++;
         tick();
         exp_op = ((63 + n) < 128) ? 8'd0 : 8'd255;
         total++; if (op !== exp_op) begin bad++; $display("FAIL sq2x_hold_op n=%0d got=%0d want=%0d", n, op, exp_op); end
         total++; if (cfg_ready !== (n == 192)) begin bad++; $display("FAIL sq2x_hold_ready n=%0d got=%0b want=%0b", n, cfg_ready, (n == 192)); end
      end
      cfg_valid = 1'b0;
      total++; if (accepts !== 1) begin bad++; $display("FAIL sq2x_accepts got=%0d want=1", accepts); end
      for (int i = 0; i < 256; i++) begin
         tick();
         exp_op = ((i & 64) != 0) ? 8'd255 : 8'd0;
         total++; if (op !== exp_op) begin bad++; $display("FAIL sq2x_op i=%0d got=%0d want=%0d", i, op, exp_op); end
      end
   endtask

   task automatic test_en_drop;
      offer(2'd1, 16'd256, 8'd128);
      tick();
      cfg_valid = 1'b0;
      repeat (69) tick();
      en = 1'b0;
      tick();
      total++; if (op !== 8'd255) begin bad++; $display("FAIL endrop_old_mode_op got=%0d want=255", op); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL endrop_wrap got=%0b want=0", wrap); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL endrop_ready got=%0b want=1", cfg_ready); end
      en = 1'b1;
      tick();
      total++; if (op !== 8'd70) begin bad++; $display("FAIL endrop_frozen_op got=%0d want=70", op); end
      tick();
      total++; if (op !== 8'd71) begin bad++; $display("FAIL endrop_next_op got=%0d want=71", op); end
   endtask

   task automatic test_reset_pending;
      offer(2'd2, 16'd1000, 8'd0);
      tick();
      cfg_valid = 1'b0;
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rstpend_accept_ready got=%0b want=0", cfg_ready); end
      repeat (5) tick();
      rst = 1'b0;
      tick();
      total++; if (op !== 8'd0) begin bad++; $display("FAIL rstpend_op got=%0d want=0", op); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL rstpend_wrap got=%0b want=0", wrap); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rstpend_ready got=%0b want=1", cfg_ready); end
   endtask

   // Duty extremes, applied instantly by halting for one edge.
   task automatic test_duty_edges;
      logic [7:0] exp_op;
      en = 1'b0;
      offer(2'd0, 16'd256, 8'd0);
      tick();
      cfg_valid = 1'b0;
      tick();
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL duty0_ready got=%0b want=1", cfg_ready); end
      en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         tick();
         total++; if (op !== 8'd255) begin bad++; $display("FAIL duty0_op i=%0d got=%0d want=255", i, op); end
      end
      en = 1'b0;
      offer(2'd0, 16'd256, 8'd255);
      tick();
      cfg_valid = 1'b0;
      tick();
      en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         tick();
         exp_op = (i == 255) ? 8'd255 : 8'd0;
         total++; if (op !== exp_op) begin bad++; $display("FAIL dutymax_op i=%0d got=%0d want=%0d", i, op, exp_op); end
      end
   endtask

   task automatic test_inc_zero;
      en = 1'b0;
      offer(2'd1, 16'd0, 8'd128);
      tick();
      cfg_valid = 1'b0;
      tick();
      en = 1'b1;
      offer(2'd0, 16'd256, 8'd128);
      tick();
      cfg_valid = 1'b0;
      for (int n = 0; n < 300; n++) begin
         tick();
         total++; if (wrap !== 1'b0) begin bad++; $display("FAIL inc0_wrap n=%0d got=%0b want=0", n, wrap); end
         total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL inc0_ready n=%0d got=%0b want=0", n, cfg_ready); end
      end
      en = 1'b0;
      tick();
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL inc0_escape_ready got=%0b want=1", cfg_ready); end
   endtask

   initial begin
      test_reset();
      test_square_default();
      test_saw_cfg();
      test_tri();
      test_square2x();
      test_en_drop();
      test_reset_pending();
      test_square_default();
      test_duty_edges();
      test_inc_zero();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
